seg7_ctrl: RTL

Responder for the bus's seg7 write port. It captures CPU writes (`seg7_we`, `cpuseg7_data`) into a 32-bit display register. It drives an 8-digit, common-anode, time-multiplexed hex display. Frames are tear-free: a shadow copy of the register is loaded only at frame boundaries. It sits in the top level beside data memory and takes the bus outputs directly.

---
 rtl/seg7_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg7_ctrl.sv
// seg7_ctrl -- CPU-writable 8-digit hex display driver.
//
// The bus writes a 32-bit display register. A shadow copy is taken only when
// the scan wraps from digit 7 back to digit 0, so each frame shows one
// consistent value. The shadow drives a time-multiplexed, common-anode,
// 8-digit display, one nibble per digit.
//
// Optional feature: define SEG7_LZB_EN to blank leading zero digits.
// Digit 0 is always shown.
//
// Parameters:
//   SCAN_CNT  - clock cycles each digit stays lit (>= 2)
//   RESET_VAL - reset value of the display and shadow registers
//
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset
//   seg7_we      - bus write strobe
//   cpuseg7_data - bus write data
//   seg7_data_o  - display register readback
//   disp_an_o    - digit anodes, active-low, bit k = digit k (0 = rightmost)
//   disp_seg_o   - segments, active-low, {dp,g,f,e,d,c,b,a}
module seg7_ctrl #(
    parameter int          SCAN_CNT  = 100000,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg7_we,
    input  logic [31:0] cpuseg7_data,
    output logic [31:0] seg7_data_o,
    output logic [7:0]  disp_an_o,
    output logic [7:0]  disp_seg_o
);

    localparam int             CW      = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_CNT - 1);

    logic [31:0]   disp_reg;
    logic [31:0]   shadow;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          cnt_last;
    logic          frame_wrap;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign cnt_last    = (cnt == CNT_MAX);
    assign frame_wrap  = cnt_last && (idx == 3'd7);
    assign nib         = shadow[{idx, 2'b00} +: 4];
    assign seg7_data_o = disp_reg;

`ifdef SEG7_LZB_EN
    // Highest nonzero nibble; stays 0 for an all-zero shadow so digit 0 is lit.
    logic [2:0] msd;
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (shadow[4*i +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end
        blank = (idx > msd);
    end
`else
    assign blank = 1'b0;
`endif

    // Display register: written by the bus, read back directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_reg <= RESET_VAL;
        end else if (seg7_we) begin
            disp_reg <= cpuseg7_data;
        end
    end

    // Scan timing: cnt sets the dwell, idx selects the digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow reload at the frame boundary; a write on that same edge bypasses
    // the display register so the new frame never shows the stale value.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= RESET_VAL;
        end else if (frame_wrap) begin
            shadow <= seg7_we ? cpuseg7_data : disp_reg;
        end
    end

    // Output stage: registered from the current idx/shadow, one cycle behind idx.
    always_ff @(posedge clk) begin
        if (rst || blank) begin
            disp_an_o  <= 8'hFF;
            disp_seg_o <= 8'hFF;
        end else begin
            disp_an_o  <= ~(8'b1 << idx);
            disp_seg_o <= hex_seg(nib);
        end
    end

endmodule
